// File: rtl/lamp_fpu_round_pack_pkg.sv
// lamp_fpu_round_pack_pkg
//   Shared definitions for the bfloat16 round/pack stage: rounding-mode
//   enum, sticky flag bit positions, BF16 special encodings and the
//   rounding-increment / overflow-target helper functions.
package lamp_fpu_round_pack_pkg;

    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;
    localparam int LAMP_FLAGS_DW   = 5;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rnd_mode_e;

    // Flag vector layout {NV,DZ,OF,UF,NX}
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    // {exponent, fraction} of BF16 infinity and largest finite magnitude
    localparam logic [14:0] INF_E_F  = {8'hFF, 7'h00};
    localparam logic [14:0] MAXF_E_F = {8'hFE, 7'h7F};

    // Round-up decision; unused mode encodings fall back to RNE.
    function automatic logic FUNC_round_inc(
        input logic       s,
        input logic       lsb,
        input logic       g,
        input logic       rs,
        input logic [2:0] mode
    );
        logic inc;
        case (mode)
            RTZ:     inc = 1'b0;
            RDN:     inc = s & (g | rs);
            RUP:     inc = ~s & (g | rs);
            RMM:     inc = g;
            default: inc = g & (rs | lsb);
        endcase
        return inc;
    endfunction

    // On overflow: 1 => saturate to infinity, 0 => clamp to max finite.
    function automatic logic FUNC_ovf_to_inf(
        input logic       s,
        input logic [2:0] mode
    );
        logic to_inf;
        case (mode)
            RTZ:     to_inf = 1'b0;
            RDN:     to_inf = s;
            RUP:     to_inf = ~s;
            default: to_inf = 1'b1;
        endcase
        return to_inf;
    endfunction

endpackage

// File: rtl/lamp_fpu_rnd_inc.sv
// lamp_fpu_rnd_inc
//   Combinational rounding-increment decision.
//   Ports:
//     s_i        sign of the value being rounded
//     lsb_i      least significant kept fraction bit
//     g_i        guard bit
//     rs_i       round | sticky
//     rnd_mode_i rounding mode (rnd_mode_e encoding)
//     inc_o      1 => add one ulp to the kept fraction
module lamp_fpu_rnd_inc
    import lamp_fpu_round_pack_pkg::*;
(
    input  logic       s_i,
    input  logic       lsb_i,
    input  logic       g_i,
    input  logic       rs_i,
    input  logic [2:0] rnd_mode_i,
    output logic       inc_o
);

    assign inc_o = FUNC_round_inc(s_i, lsb_i, g_i, rs_i, rnd_mode_i);

endmodule

// File: rtl/lamp_fpu_round_pack.sv
// lamp_fpu_round_pack
//   Rounds a post-normalised {s, e, f+GRS} value, packs it into bfloat16,
//   holds it in a valid/ready output register and accumulates sticky flags.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     valid_i / ready_o     upstream handshake (ready_o = !valid_o | ready_i)
//     s_i, e_i, f_i         sign, biased exponent, {ovf,hidden,frac,G,R,S}
//     isToRound_i           0 => value already encoded, pass through
//     isOverflow_i          upstream overflow
//     isUnderflow_i         upstream underflow
//     isInvalid_i           upstream invalid operation
//     rnd_mode_i            rounding mode
//     valid_o / ready_i     downstream handshake
//     res_o, flags_o        packed result and its flags
//     fflags_o              sticky flags; fflags_clr_i clears them
module lamp_fpu_round_pack
    import lamp_fpu_round_pack_pkg::*;
#(
    parameter int E_DW     = LAMP_FLOAT_E_DW,
    parameter int F_DW     = LAMP_FLOAT_F_DW,
    parameter int FLAGS_DW = LAMP_FLAGS_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   s_i,
    input  logic [E_DW-1:0]        e_i,
    input  logic [F_DW+4:0]        f_i,
    input  logic                   isToRound_i,
    input  logic                   isOverflow_i,
    input  logic                   isUnderflow_i,
    input  logic                   isInvalid_i,
    input  logic [2:0]             rnd_mode_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [E_DW+F_DW:0]     res_o,
    output logic [FLAGS_DW-1:0]    flags_o,
    output logic [FLAGS_DW-1:0]    fflags_o,
    input  logic                   fflags_clr_i
);

    localparam int EF_DW = E_DW + F_DW;

    logic                 inc;
    logic                 g_bit;
    logic                 rs_bit;
    logic                 nx_raw;
    logic                 ovf;
    logic [EF_DW-1:0]     ef_r;
    logic [E_DW-1:0]      e_r;
    logic [EF_DW:0]       new_res;
    logic [FLAGS_DW-1:0]  new_flags;
    logic                 accept;

    logic                 valid_d,  valid_q;
    logic [EF_DW:0]       res_d,    res_q;
    logic [FLAGS_DW-1:0]  flags_d,  flags_q;
    logic [FLAGS_DW-1:0]  fflags_d, fflags_q;

    assign g_bit  = f_i[2];
    assign rs_bit = f_i[1] | f_i[0];
    assign nx_raw = g_bit | rs_bit;

    lamp_fpu_rnd_inc u_rnd_inc (
        .s_i        (s_i),
        .lsb_i      (f_i[3]),
        .g_i        (g_bit),
        .rs_i       (rs_bit),
        .rnd_mode_i (rnd_mode_i),
        .inc_o      (inc)
    );

    // A single add over {e, frac}: a fraction carry ripples into the exponent,
    // which also covers the denormal -> smallest normal transition.
    assign ef_r = {e_i, f_i[F_DW+2:3]} + EF_DW'(inc);
    assign e_r  = ef_r[EF_DW-1:F_DW];
    assign ovf  = isOverflow_i | (e_r == {E_DW{1'b1}});

    always_comb begin
        new_res   = '0;
        new_flags = '0;
        if (!isToRound_i) begin
            new_res            = {s_i, e_i, f_i[F_DW+2:3]};
            new_flags[FLAG_NV] = isInvalid_i;
        end else if ((e_i == '0) && (f_i == '0)) begin
            new_res = {s_i, {EF_DW{1'b0}}};
        end else begin
            if (ovf) begin
                if (FUNC_ovf_to_inf(s_i, rnd_mode_i))
                    new_res = {s_i, {E_DW{1'b1}}, {F_DW{1'b0}}};
                else
                    new_res = {s_i, {(E_DW-1){1'b1}}, 1'b0, {F_DW{1'b1}}};
                new_flags[FLAG_OF] = 1'b1;
                new_flags[FLAG_NX] = 1'b1;
            end else begin
                new_res            = {s_i, ef_r};
                new_flags[FLAG_NX] = nx_raw;
            end
            new_flags[FLAG_UF] = isUnderflow_i | ((e_r == '0) & nx_raw);
            new_flags[FLAG_NV] = isInvalid_i;
        end
    end

    assign ready_o = ~valid_q | ready_i;
    assign accept  = valid_i & ready_o;

    always_comb begin
        valid_d  = valid_q;
        res_d    = res_q;
        flags_d  = flags_q;
        fflags_d = fflags_q;
        if (accept) begin
            valid_d = 1'b1;
            res_d   = new_res;
            flags_d = new_flags;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
        // Clear takes effect before the OR, so a same-cycle accept survives.
        if (fflags_clr_i)
            fflags_d = '0;
        if (accept)
            fflags_d = fflags_d | new_flags;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
            fflags_q <= '0;
        end else begin
            valid_q  <= valid_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            fflags_q <= fflags_d;
        end
    end

    assign valid_o  = valid_q;
    assign res_o    = res_q;
    assign flags_o  = flags_q;
    assign fflags_o = fflags_q;

endmodule

// File: tb/tb_lamp_fpu_round_pack.sv
module tb_lamp_fpu_round_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic        s_i;
    logic [7:0]  e_i;
    logic [11:0] f_i;
    logic        isToRound_i;
    logic        isOverflow_i;
    logic        isUnderflow_i;
    logic        isInvalid_i;
    logic [2:0]  rnd_mode_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] res_o;
    logic [4:0]  flags_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i;

    int passes = 0;
    int total  = 0;

    localparam logic [2:0] M_RNE = 3'd0;
    localparam logic [2:0] M_RTZ = 3'd1;
    localparam logic [2:0] M_RDN = 3'd2;
    localparam logic [2:0] M_RUP = 3'd3;
    localparam logic [2:0] M_RMM = 3'd4;

    always #5 clk = ~clk;

    lamp_fpu_round_pack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .s_i           (s_i),
        .e_i           (e_i),
        .f_i           (f_i),
        .isToRound_i   (isToRound_i),
        .isOverflow_i  (isOverflow_i),
        .isUnderflow_i (isUnderflow_i),
        .isInvalid_i   (isInvalid_i),
        .rnd_mode_i    (rnd_mode_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .res_o         (res_o),
        .flags_o       (flags_o),
        .fflags_o      (fflags_o),
        .fflags_clr_i  (fflags_clr_i)
    );

    function automatic logic [11:0] mkf(input logic hid, input logic [6:0] fr, input logic [2:0] grs);
        return {1'b0, hid, fr, grs};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_in(input logic s, input logic [7:0] e, input logic [11:0] f,
                          input logic tr, input logic ov, input logic un,
                          input logic inv, input logic [2:0] mode);
        s_i = s; e_i = e; f_i = f;
        isToRound_i = tr; isOverflow_i = ov; isUnderflow_i = un;
        isInvalid_i = inv; rnd_mode_i = mode;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One input beat; the caller guarantees ready_o is high at the edge.
    task automatic send(input logic s, input logic [7:0] e, input logic [11:0] f,
                        input logic tr, input logic ov, input logic un,
                        input logic inv, input logic [2:0] mode);
        set_in(s, e, f, tr, ov, un, inv, mode);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; fflags_clr_i = 1'b0;
        set_in(1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, M_RNE);

        #3;
        chk("rst_valid", 16'(valid_o), 16'h0);
        chk("rst_res", res_o, 16'h0000);
        chk("rst_flags", 16'(flags_o), 16'h0);
        chk("rst_fflags", 16'(fflags_o), 16'h0);
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("rst_ready", 16'(ready_o), 16'h1);

        // RNE tie: odd lsb rounds up, even lsb stays
        send(1'b0, 8'h7F, mkf(1'b1, 7'h01, 3'b100), 1'b1, 1'b0, 1'b0, 1'b0, M_RNE);
        chk("rne_tie_odd_valid", 16'(valid_o), 16'h1);
        chk("rne_tie_odd", res_o, 16'h3F82);
        chk("rne_tie_odd_fl", 16'(flags_o), 16'h01);
        send(1'b0, 8'h7F, mkf(1'b1, 7'h02, 3'b100), 1'b1, 1'b0, 1'b0, 1'b0, M_RNE);
        chk("rne_tie_even", res_o, 16'h3F82);
        chk("rne_tie_even_fl", 16'(flags_o), 16'h01);

        // Mantissa carry into exponent, and carry into all-ones exponent
        send(1'b0, 8'h80, mkf(1'b1, 7'h7F, 3'b100), 1'b1, 1'b0, 1'b0, 1'b0, M_RNE);
        chk("carry", res_o, 16'h4080);
        send(1'b0, 8'hFE, mkf(1'b1, 7'h7F, 3'b100), 1'b1, 1'b0, 1'b0, 1'b0, M_RNE);
        chk("carry_inf", res_o, 16'h7F80);
        chk("carry_inf_fl", 16'(flags_o), 16'h05);

        // Upstream overflow clamps to max finite under RTZ / directed-away modes
        send(1'b1, 8'hFE, mkf(1'b1, 7'h7F, 3'b000), 1'b1, 1'b1, 1'b0, 1'b0, M_RTZ);
        chk("ovf_rtz", res_o, 16'hFF7F);
        chk("ovf_rtz_fl", 16'(flags_o), 16'h05);
        send(1'b0, 8'hFE, mkf(1'b1, 7'h7F, 3'b000), 1'b1, 1'b1, 1'b0, 1'b0, M_RDN);
        chk("ovf_rdn_pos", res_o, 16'h7F7F);
        send(1'b1, 8'hFE, mkf(1'b1, 7'h7F, 3'b000), 1'b1, 1'b1, 1'b0, 1'b0, M_RDN);
        chk("ovf_rdn_neg", res_o, 16'hFF80);

        // Directed modes on a round-bit-only remainder
        send(1'b0, 8'h7F, mkf(1'b1, 7'h00, 3'b010), 1'b1, 1'b0, 1'b0, 1'b0, M_RUP);
        chk("rup_pos", res_o, 16'h3F81);
        send(1'b0, 8'h7F, mkf(1'b1, 7'h00, 3'b010), 1'b1, 1'b0, 1'b0, 1'b0, M_RDN);
        chk("rdn_pos", res_o, 16'h3F80);
        chk("rdn_pos_fl", 16'(flags_o), 16'h01);
        send(1'b1, 8'h7F, mkf(1'b1, 7'h00, 3'b010), 1'b1, 1'b0, 1'b0, 1'b0, M_RDN);
        chk("rdn_neg", res_o, 16'hBF81);
        send(1'b0, 8'h7F, mkf(1'b1, 7'h02, 3'b100), 1'b1, 1'b0, 1'b0, 1'b0, M_RMM);
        chk("rmm_tie", res_o, 16'h3F83);
        send(1'b0, 8'h7F, mkf(1'b1, 7'h02, 3'b110), 1'b1, 1'b0, 1'b0, 1'b0, M_RTZ);
        chk("rtz_trunc", res_o, 16'h3F82);
        send(1'b0, 8'h7F, mkf(1'b1, 7'h01, 3'b100), 1'b1, 1'b0, 1'b0, 1'b0, 3'd5);
        chk("mode5_rne", res_o, 16'h3F82);

        // Signed zero, denorm -> normal, passthrough NaN
        send(1'b1, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, M_RUP);
        chk("zero", res_o, 16'h8000);
        chk("zero_fl", 16'(flags_o), 16'h00);
        send(1'b0, 8'h00, mkf(1'b0, 7'h7F, 3'b100), 1'b1, 1'b0, 1'b0, 1'b0, M_RNE);
        chk("denorm_norm", res_o, 16'h0080);
        chk("denorm_norm_fl", 16'(flags_o), 16'h01);
        send(1'b0, 8'hFF, mkf(1'b1, 7'h40, 3'b000), 1'b0, 1'b0, 1'b0, 1'b1, M_RNE);
        chk("pass_nan", res_o, 16'h7FC0);
        chk("pass_nan_fl", 16'(flags_o), 16'h10);

        // Sticky flags: clear, UF op, NX op, clear concurrent with OF op
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        chk("ff_clear", 16'(fflags_o), 16'h00);
        send(1'b0, 8'h00, mkf(1'b0, 7'h01, 3'b100), 1'b1, 1'b0, 1'b0, 1'b0, M_RNE);
        chk("uf_res", res_o, 16'h0002);
        chk("ff_uf", 16'(fflags_o), 16'h03);
        send(1'b0, 8'h7F, mkf(1'b1, 7'h01, 3'b100), 1'b1, 1'b0, 1'b0, 1'b0, M_RNE);
        chk("ff_nx", 16'(fflags_o), 16'h03);
        fflags_clr_i = 1'b1;
        send(1'b1, 8'hFE, mkf(1'b1, 7'h7F, 3'b000), 1'b1, 1'b1, 1'b0, 1'b0, M_RTZ);
        fflags_clr_i = 1'b0;
        chk("ff_clr_of", 16'(fflags_o), 16'h05);

        // Backpressure: A accepted, B held for three stalled cycles
        step();
        chk("bp_idle", 16'(valid_o), 16'h0);
        ready_i = 1'b0;
        send(1'b0, 8'h7F, mkf(1'b1, 7'h01, 3'b100), 1'b1, 1'b0, 1'b0, 1'b0, M_RNE);
        chk("bp_a", res_o, 16'h3F82);
        set_in(1'b0, 8'h7F, mkf(1'b1, 7'h00, 3'b010), 1'b1, 1'b0, 1'b0, 1'b0, M_RUP);
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 16'(ready_o), 16'h0);
            step();
            chk("bp_hold_res", res_o, 16'h3F82);
            chk("bp_hold_valid", 16'(valid_o), 16'h1);
        end
        ready_i = 1'b1;
        #1;
        chk("bp_ready_up", 16'(ready_o), 16'h1);
        step();
        valid_i = 1'b0;
        chk("bp_b", res_o, 16'h3F81);
        chk("bp_b_valid", 16'(valid_o), 16'h1);
        step();
        chk("bp_drain", 16'(valid_o), 16'h0);

        // Asynchronous reset during a stall
        ready_i = 1'b0;
        send(1'b0, 8'h80, mkf(1'b1, 7'h7F, 3'b100), 1'b1, 1'b0, 1'b0, 1'b0, M_RNE);
        chk("stall_valid", 16'(valid_o), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 16'(valid_o), 16'h0);
        chk("async_rst_res", res_o, 16'h0000);
        chk("async_rst_ff", 16'(fflags_o), 16'h00);
        @(negedge clk);
        rst_n = 1'b1;
        ready_i = 1'b1;
        step();
        chk("post_rst_ready", 16'(ready_o), 16'h1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
